// File: rtl/y_line_buffer_if.sv
// Pixel stream in, aligned 5-row column out, for the y line buffer.
interface y_line_buffer_if #(
  parameter int COL_BITS = 10
);
  logic                sof;
  logic [7:0]          din;
  logic                validin;
  logic [7:0]          dout0;
  logic [7:0]          dout1;
  logic [7:0]          dout2;
  logic [7:0]          dout3;
  logic [7:0]          dout4;
  logic [2:0]          hsel;
  logic                validout;
  logic [COL_BITS-1:0] col_out;

  // Pixel source side: drives the stream and consumes the columns.
  modport master (
    output sof, din, validin,
    input  dout0, dout1, dout2, dout3, dout4, hsel, validout, col_out
  );

  // Line buffer side.
  modport slave (
    input  sof, din, validin,
    output dout0, dout1, dout2, dout3, dout4, hsel, validout, col_out
  );
endinterface

// File: rtl/y_line_buffer.sv
// Five circular single-line banks feeding the 5-tap vertical filter.
// Rows are never shifted; hsel tells the filter which bank holds the
// oldest line so it can rotate its coefficients instead.
module y_line_buffer #(
  parameter int LINE_WIDTH = 640,
  parameter int COL_BITS   = 10
) (
  input logic           clock,
  input logic           reset,
  y_line_buffer_if.slave bus
);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(LINE_WIDTH - 1);

  logic [COL_BITS-1:0] col;
  logic [2:0]          wbank;
  logic [2:0]          lines_filled;

  logic                accept;
  logic [COL_BITS-1:0] eff_col;
  logic [2:0]          eff_wbank;
  logic [2:0]          eff_filled;
  logic [2:0]          next_wbank;
  logic [2:0]          next_filled;
  logic                end_of_line;

  assign accept = bus.validin;

  // A qualified sof restarts the frame on this very pixel, so the pixel
  // itself is processed as column 0 of line 0 in bank 0.
  always_comb begin
    eff_col    = col;
    eff_wbank  = wbank;
    eff_filled = lines_filled;
    if (bus.sof) begin
      eff_col    = '0;
      eff_wbank  = 3'd0;
      eff_filled = 3'd0;
    end
  end

  assign end_of_line = (eff_col == LAST_COL);
  assign next_wbank  = (eff_wbank == 3'd4) ? 3'd0 : eff_wbank + 3'd1;
  assign next_filled = (eff_filled == 3'd4) ? 3'd4 : eff_filled + 3'd1;

  // Position counters advance only on accepted pixels; line ends rotate the write bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      col          <= '0;
      wbank        <= 3'd0;
      lines_filled <= 3'd0;
    end else if (accept) begin
      if (end_of_line) begin
        col          <= '0;
        wbank        <= next_wbank;
        lines_filled <= next_filled;
      end else begin
        col          <= eff_col + COL_BITS'(1);
        wbank        <= eff_wbank;
        lines_filled <= eff_filled;
      end
    end
  end

  // Column metadata registers; validout pulses only when four full lines sit behind this pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.validout <= 1'b0;
      bus.hsel     <= 3'd1;
      bus.col_out  <= '0;
    end else begin
      bus.validout <= accept && (eff_filled == 3'd4);
      if (accept) begin
        bus.hsel    <= next_wbank;
        bus.col_out <= eff_col;
      end
    end
  end

  for (genvar k = 0; k < 5; k++) begin : g_bank
    logic [7:0] mem [LINE_WIDTH];
    logic [7:0] q;
    logic       hit;

    assign hit = (eff_wbank == 3'(k));

    // Line storage; contents survive reset and are simply overwritten.
    always_ff @(posedge clock) begin
      if (!reset && accept && hit) begin
        mem[eff_col] <= bus.din;
      end
    end

    // Registered read with write-first bypass so the bank being written shows the live pixel.
    always_ff @(posedge clock) begin
      if (reset) begin
        q <= 8'd0;
      end else if (accept) begin
        q <= hit ? bus.din : mem[eff_col];
      end
    end
  end

  assign bus.dout0 = g_bank[0].q;
  assign bus.dout1 = g_bank[1].q;
  assign bus.dout2 = g_bank[2].q;
  assign bus.dout3 = g_bank[3].q;
  assign bus.dout4 = g_bank[4].q;
endmodule

// File: tb/tb_y_line_buffer.sv
// Directed bench for y_line_buffer with an 8-pixel line.
module tb_y_line_buffer;
  localparam int LW = 8;
  localparam int CB = 3;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   ref_cols[$];

  y_line_buffer_if #(.COL_BITS(CB)) bus ();

  y_line_buffer #(.LINE_WIDTH(LW), .COL_BITS(CB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // 100 MHz-style free-running clock.
  always #5 clock = ~clock;

  // Present one cycle of input, then observe just after the capturing edge.
  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
    bus.validin = v;
    bus.sof     = s;
    bus.din     = d;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] dout_of(input int b);
    case (b)
      0: return bus.dout0;
      1: return bus.dout1;
      2: return bus.dout2;
      3: return bus.dout3;
      default: return bus.dout4;
    endcase
  endfunction

  // Most recent line L <= line with L mod 5 == b, as pixel base+16*L+col.
  function automatic logic [7:0] exp_dout(input int b, input int line, input int col, input int base);
    for (int l = line; l >= 0 && l >= line - 4; l--) begin
      if (l % 5 == b) return 8'(base + 16 * l + col);
    end
    return 8'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'hAA);
    applyStimulus(1'b1, 1'b0, 8'h55);
    checks++;
    if (bus.validout !== 1'b0) begin errors++; $display("[TB] FAIL reset_validout: got %0d expected 0", bus.validout); end
    checks++;
    if (bus.hsel !== 3'd1) begin errors++; $display("[TB] FAIL reset_hsel: got %0d expected 1", bus.hsel); end
    checks++;
    if (bus.col_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_col_out: got %0d expected 0", bus.col_out); end
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (dout_of(b) !== 8'd0) begin errors++; $display("[TB] FAIL reset_dout%0d: got %0d expected 0", b, dout_of(b)); end
    end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < LW; c++) begin
        applyStimulus(1'b1, (l == 0 && c == 0), 8'(16 * l + c));
        checks++;
        if (bus.validout !== 1'b0) begin errors++; $display("[TB] FAIL fill_validout l%0d c%0d: got %0d expected 0", l, c, bus.validout); end
      end
    end
    applyStimulus(1'b1, 1'b0, 8'd64);
    checks++;
    if (bus.validout !== 1'b1) begin errors++; $display("[TB] FAIL first_validout: got %0d expected 1", bus.validout); end
    checks++;
    if (bus.hsel !== 3'd0) begin errors++; $display("[TB] FAIL first_hsel: got %0d expected 0", bus.hsel); end
    checks++;
    if (bus.col_out !== 3'd0) begin errors++; $display("[TB] FAIL first_col_out: got %0d expected 0", bus.col_out); end
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (dout_of(b) !== 8'(16 * b)) begin errors++; $display("[TB] FAIL first_dout%0d: got %0d expected %0d", b, dout_of(b), 16 * b); end
    end
    for (int c = 1; c < LW; c++) applyStimulus(1'b1, 1'b0, 8'(64 + c));
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, 8'(80 + c));
    checks++;
    if (bus.dout0 !== 8'd83) begin errors++; $display("[TB] FAIL wrap_dout0: got %0d expected 83", bus.dout0); end
    checks++;
    if (bus.dout1 !== 8'd19) begin errors++; $display("[TB] FAIL wrap_dout1: got %0d expected 19", bus.dout1); end
    checks++;
    if (bus.dout2 !== 8'd35) begin errors++; $display("[TB] FAIL wrap_dout2: got %0d expected 35", bus.dout2); end
    checks++;
    if (bus.dout3 !== 8'd51) begin errors++; $display("[TB] FAIL wrap_dout3: got %0d expected 51", bus.dout3); end
    checks++;
    if (bus.dout4 !== 8'd67) begin errors++; $display("[TB] FAIL wrap_dout4: got %0d expected 67", bus.dout4); end
    checks++;
    if (bus.hsel !== 3'd1) begin errors++; $display("[TB] FAIL wrap_hsel: got %0d expected 1", bus.hsel); end
    checks++;
    if (bus.col_out !== 3'd3) begin errors++; $display("[TB] FAIL wrap_col_out: got %0d expected 3", bus.col_out); end
    applyStimulus(1'b0, 1'b0, 8'hEE);
    checks++;
    if (bus.validout !== 1'b0) begin errors++; $display("[TB] FAIL idle_validout: got %0d expected 0", bus.validout); end
    checks++;
    if (bus.dout0 !== 8'd83 || bus.hsel !== 3'd1 || bus.col_out !== 3'd3) begin
      errors++; $display("[TB] FAIL idle_hold: got dout0=%0d hsel=%0d col=%0d expected 83/1/3", bus.dout0, bus.hsel, bus.col_out);
    end
  endtask

  task automatic test_stream();
    int nvalid;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    ref_cols.delete();
    for (int l = 0; l < 12; l++) begin
      nvalid = 0;
      for (int c = 0; c < LW; c++) begin
        applyStimulus(1'b1, (l == 0 && c == 0), 8'(16 * l + c));
        checks++;
        if (bus.validout !== (l >= 4)) begin errors++; $display("[TB] FAIL stream_validout l%0d c%0d: got %0d expected %0d", l, c, bus.validout, l >= 4); end
        if (bus.validout === 1'b1) begin
          nvalid++;
          ref_cols.push_back(int'(bus.col_out));
        end
        if (l >= 4) begin
          checks++;
          if (bus.hsel !== 3'((l % 5 + 1) % 5)) begin errors++; $display("[TB] FAIL stream_hsel l%0d c%0d: got %0d expected %0d", l, c, bus.hsel, (l % 5 + 1) % 5); end
          checks++;
          if (bus.col_out !== 3'(c)) begin errors++; $display("[TB] FAIL stream_col l%0d c%0d: got %0d expected %0d", l, c, bus.col_out, c); end
          for (int b = 0; b < 5; b++) begin
            checks++;
            if (dout_of(b) !== exp_dout(b, l, c, 0)) begin
              errors++; $display("[TB] FAIL stream_dout%0d l%0d c%0d: got %0d expected %0d", b, l, c, dout_of(b), exp_dout(b, l, c, 0));
            end
          end
        end
      end
      checks++;
      if (nvalid != ((l >= 4) ? LW : 0)) begin errors++; $display("[TB] FAIL stream_count l%0d: got %0d expected %0d", l, nvalid, (l >= 4) ? LW : 0); end
    end
  endtask

  task automatic test_gaps();
    int got_cols[$];
    int p;
    logic [7:0] h_dout2;
    logic [2:0] h_hsel;
    logic [CB-1:0] h_col;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    for (int l = 0; l < 12; l++) begin
      for (int c = 0; c < LW; c++) begin
        p = l * LW + c;
        applyStimulus(1'b1, (l == 0 && c == 0), 8'(16 * l + c));
        if (bus.validout === 1'b1) begin
          got_cols.push_back(int'(bus.col_out));
          checks++;
          if (bus.dout2 !== exp_dout(2, l, c, 0)) begin errors++; $display("[TB] FAIL gap_dout2 l%0d c%0d: got %0d expected %0d", l, c, bus.dout2, exp_dout(2, l, c, 0)); end
        end
        h_dout2 = bus.dout2;
        h_hsel  = bus.hsel;
        h_col   = bus.col_out;
        if (p % 5 == 2 || c == LW - 1) begin
          for (int g = 0; g <= p % 3; g++) begin
            applyStimulus(1'b0, 1'b0, 8'hFF);
            checks++;
            if (bus.validout !== 1'b0) begin errors++; $display("[TB] FAIL gap_validout p%0d: got %0d expected 0", p, bus.validout); end
            checks++;
            if (bus.dout2 !== h_dout2 || bus.hsel !== h_hsel || bus.col_out !== h_col) begin
              errors++; $display("[TB] FAIL gap_hold p%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", p, bus.dout2, bus.hsel, bus.col_out, h_dout2, h_hsel, h_col);
            end
          end
        end
      end
    end
    checks++;
    if (got_cols.size() != ref_cols.size()) begin
      errors++; $display("[TB] FAIL gap_col_count: got %0d expected %0d", got_cols.size(), ref_cols.size());
    end else begin
      for (int i = 0; i < got_cols.size(); i++) begin
        checks++;
        if (got_cols[i] != ref_cols[i]) begin errors++; $display("[TB] FAIL gap_col_seq[%0d]: got %0d expected %0d", i, got_cols[i], ref_cols[i]); end
      end
    end
  endtask

  task automatic test_sof_mid();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < LW; c++) applyStimulus(1'b1, (l == 0 && c == 0), 8'(16 * l + c));
    end
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b0, 8'(96 + c));
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < LW; c++) begin
        applyStimulus(1'b1, (l == 0 && c == 0), 8'(128 + 16 * l + c));
        checks++;
        if (bus.validout !== 1'b0) begin errors++; $display("[TB] FAIL sof_validout l%0d c%0d: got %0d expected 0", l, c, bus.validout); end
      end
    end
    applyStimulus(1'b1, 1'b0, 8'd192);
    checks++;
    if (bus.validout !== 1'b1) begin errors++; $display("[TB] FAIL sof_first_validout: got %0d expected 1", bus.validout); end
    checks++;
    if (bus.hsel !== 3'd0) begin errors++; $display("[TB] FAIL sof_first_hsel: got %0d expected 0", bus.hsel); end
    checks++;
    if (bus.col_out !== 3'd0) begin errors++; $display("[TB] FAIL sof_first_col: got %0d expected 0", bus.col_out); end
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (dout_of(b) !== 8'(128 + 16 * b)) begin errors++; $display("[TB] FAIL sof_first_dout%0d: got %0d expected %0d", b, dout_of(b), 128 + 16 * b); end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    for (int l = 0; l < 5; l++) begin
      for (int c = 0; c < LW; c++) applyStimulus(1'b1, (l == 0 && c == 0), 8'(16 * l + c));
    end
    for (int c = 0; c < 2; c++) applyStimulus(1'b1, 1'b0, 8'(80 + c));
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd82);
    reset = 1'b0;
    checks++;
    if (bus.validout !== 1'b0) begin errors++; $display("[TB] FAIL rmid_validout: got %0d expected 0", bus.validout); end
    checks++;
    if (bus.hsel !== 3'd1) begin errors++; $display("[TB] FAIL rmid_hsel: got %0d expected 1", bus.hsel); end
    checks++;
    if (bus.col_out !== 3'd0) begin errors++; $display("[TB] FAIL rmid_col: got %0d expected 0", bus.col_out); end
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (dout_of(b) !== 8'd0) begin errors++; $display("[TB] FAIL rmid_dout%0d: got %0d expected 0", b, dout_of(b)); end
    end
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < LW; c++) begin
        applyStimulus(1'b1, 1'b0, 8'(16 * l + c + 1));
        checks++;
        if (bus.validout !== 1'b0) begin errors++; $display("[TB] FAIL rmid_fill l%0d c%0d: got %0d expected 0", l, c, bus.validout); end
      end
    end
    applyStimulus(1'b1, 1'b0, 8'd65);
    checks++;
    if (bus.validout !== 1'b1) begin errors++; $display("[TB] FAIL rmid_resume_validout: got %0d expected 1", bus.validout); end
    checks++;
    if (bus.hsel !== 3'd0) begin errors++; $display("[TB] FAIL rmid_resume_hsel: got %0d expected 0", bus.hsel); end
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (dout_of(b) !== 8'(16 * b + 1)) begin errors++; $display("[TB] FAIL rmid_resume_dout%0d: got %0d expected %0d", b, dout_of(b), 16 * b + 1); end
    end
  endtask

  // Scenario sequence; every task leaves the inputs in a defined state.
  initial begin
    reset       = 1'b1;
    bus.validin = 1'b0;
    bus.sof     = 1'b0;
    bus.din     = 8'd0;
    @(posedge clock);
    #1;
    test_reset();
    test_fill();
    test_stream();
    test_gaps();
    test_sof_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
